mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit between the EX/MEM pipeline register and MEM2WB.
- Performs MIPS loads and stores (byte, halfword, word; signed or unsigned loads) over a req/gnt + rvalid data-memory handshake.
- Stalls the pipeline while an access is outstanding.
- Drives regwrite_mem, memtoreg_mem, aluout_mem, readdata_mem and regaddr_mem straight into MEM2WB.

Parameters:
- WIDTH, 32, datapath/address width; byte-lane logic fixed at 4 lanes, so WIDTH must be 32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  EX/MEM slot holds a real instruction.
- memread_in  in  1  load.
- memwrite_in  in  1  store.
- size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- unsigned_in  in  1  zero-extend loads (lbu/lhu).
- regwrite_in  in  1  from EX/MEM.
- memtoreg_in  in  1  from EX/MEM.
- aluout_in  in  WIDTH  effective address / ALU result.
- writedata_in  in  WIDTH  store data (low bits significant).
- regaddr_in  in  5  destination register.
- stall_mem  out  1  freeze PC/IF/ID/EX/EX-MEM registers.
- misalign_mem  out  1  one-cycle misaligned-access flag.
- regwrite_mem  out  1  to MEM2WB.
- memtoreg_mem  out  1  to MEM2WB.
- aluout_mem  out  WIDTH  to MEM2WB.
- readdata_mem  out  WIDTH  extended load data to MEM2WB.
- regaddr_mem  out  5  to MEM2WB.
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  WIDTH  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  WIDTH  lane-replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rdata  in  WIDTH  read word.
- dmem_rvalid  in  1  read data valid.

Behaviour:
- FSM states: IDLE, REQ, RESP. Registered state plus a capture register holding all *_in fields.
- Reset: state IDLE, capture cleared. While rst=1 all outputs are 0. Reset mid-access drops the request; dmem_req is 0 from the reset cycle on, and a late rvalid/gnt is ignored.
- Start condition, in IDLE: mem_op = valid_in & (memread_in | memwrite_in).
- Non-memory op or valid_in=0 in IDLE:
  - Zero-latency combinational pass-through; stall_mem=0; readdata_mem=0.
  - valid_in=0 forces regwrite_mem=0.
- Alignment check, in IDLE when mem_op=1: misaligned if half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned: misalign_mem=1 that cycle, no memory access, regwrite_mem=0, stall_mem=0, state stays IDLE.
- Aligned mem_op in IDLE:
  - Capture inputs; stall_mem=1; outputs are a bubble (regwrite_mem=0, memtoreg_mem=0); next state REQ.
- REQ state:
  - dmem_req=1 with address, we, be and wdata taken from the capture register.
  - Request is held stable until dmem_gnt.
  - Store, gnt=1: the op completes this cycle. Outputs carry the captured fields (regwrite as captured), stall_mem=0, next state IDLE.
  - Load, gnt=1: stall_mem=1, bubble, next state RESP.
  - gnt=0: stall_mem=1, bubble, stay in REQ.
- RESP state (load):
  - dmem_req=0.
  - rvalid=0: stall, bubble, stay.
  - rvalid=1: readdata_mem = extracted and extended lane; outputs carry the captured fields; stall_mem=0; next state IDLE.
- Minimum load cost is 2 stall cycles: capture, REQ with gnt, RESP with rvalid. Minimum store cost is 1 stall cycle.
- Lanes are little-endian; lane = addr[1:0].
  - Byte store: wdata = {4{wd[7:0]}}, be = 4'b0001 << addr[1:0].
  - Half store: wdata = {2{wd[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word store: be = 1111.
- Load extraction: byte = rdata[8*lane +: 8]; half = rdata[16*addr[1] +: 16].
  - Sign-extended unless unsigned_in; a word load passes rdata through.
- Upstream holds *_in stable while stall_mem=1, but the unit uses only captured values after IDLE.
- A new op is accepted in IDLE only, on the cycle after completion. Back-to-back memory ops therefore each pay the full cost.
- dmem_req never asserts while in IDLE or RESP. At most one access is outstanding.

Decomposition:
- Shared defines: WIDTH, size codes (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encodings.
- One sub-module, mem_lane_align (combinational):
  - store path: addr, size, wdata -> be, wdata.
  - load path: addr, size, unsigned, rdata -> extended data.

Test Plan:
- ALU op: valid=1, memread=memwrite=0, aluout=0x1234, regaddr=5, regwrite=1 -> same cycle regwrite_mem=1, aluout_mem=0x1234, regaddr_mem=5, stall_mem=0, dmem_req never asserted.
- lw at 0x100, gnt immediate, rvalid next cycle, rdata=0xDEADBEEF -> stall_mem=1 for 2 cycles, dmem_addr=0x100, be=1111; then readdata_mem=0xDEADBEEF, memtoreg_mem=1, stall_mem=0.
- lb 0x103 with rdata=0x80000000 -> readdata_mem=0xFFFFFF80; lbu -> 0x00000080; lh 0x102 with rdata=0x8001_0000 -> 0xFFFF8001.
- sh 0x106, writedata=0xABCD, gnt held low 3 cycles -> dmem_req/addr=0x104/be=1100/wdata=0xABCDABCD stable for 4 cycles; stall_mem drops on the gnt cycle.
- lw 0x102 (misaligned) -> misalign_mem=1 for one cycle, regwrite_mem=0, no dmem_req, no stall.
- rst=1 asserted while in RESP, then rvalid arrives -> state IDLE, no regwrite_mem, stall_mem=0, the next ALU op passes normally.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared widths, size codes, FSM encoding and capture payload for the MEM-stage access unit.
package mem_access_stage_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NLANES = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              memread;
    logic              memwrite;
    logic [SIZE_W-1:0] size;
    logic              unsigned_ld;
    logic              regwrite;
    logic              memtoreg;
    logic [WIDTH-1:0]  aluout;
    logic [WIDTH-1:0]  writedata;
    logic [REG_W-1:0]  regaddr;
  } cap_t;

  // Half needs addr[0]=0; word (and the 2'b11 alias) needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/gnt + rvalid bus between the MEM stage and the data memory.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic             dmem_req;
  logic             dmem_we;
  logic [WIDTH-1:0] dmem_addr;
  logic [NLANES-1:0] dmem_be;
  logic [WIDTH-1:0] dmem_wdata;
  logic             dmem_gnt;
  logic [WIDTH-1:0] dmem_rdata;
  logic             dmem_rvalid;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rdata, dmem_rvalid
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rdata, dmem_rvalid
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store replication/byte enables and load extraction/extension.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]        lane,
  input  logic [SIZE_W-1:0] size,
  input  logic              unsigned_ld,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [WIDTH-1:0]  rdata,
  output logic [NLANES-1:0] be_c,
  output logic [WIDTH-1:0]  wdata_c,
  output logic [WIDTH-1:0]  rdata_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be_c    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  assign byte_v = rdata[{lane, 3'b000} +: 8];
  assign half_v = rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    rdata_c = rdata;
    case (size)
      SZ_BYTE: rdata_c = unsigned_ld ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: rdata_c = unsigned_ld ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: rdata_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: stalls the pipe while one data-memory access is outstanding
// and feeds MEM2WB combinationally from either the live EX/MEM fields or the capture register.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic [SIZE_W-1:0] size_in,
  input  logic              unsigned_in,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic [WIDTH-1:0]  aluout_in,
  input  logic [WIDTH-1:0]  writedata_in,
  input  logic [REG_W-1:0]  regaddr_in,
  output logic              stall_mem,
  output logic              misalign_mem,
  output logic              regwrite_mem,
  output logic              memtoreg_mem,
  output logic [WIDTH-1:0]  aluout_mem,
  output logic [WIDTH-1:0]  readdata_mem,
  output logic [REG_W-1:0]  regaddr_mem,
  mem_access_stage_if.master dmem
);

  state_e state_q, state_d;
  cap_t   cap_q, cap_d;

  logic              mem_op_c;
  logic              misaligned_c;
  logic              is_load_c;
  logic [NLANES-1:0] be_c;
  logic [WIDTH-1:0]  wdata_c;
  logic [WIDTH-1:0]  rdata_c;

  assign mem_op_c     = valid_in & (memread_in | memwrite_in);
  assign misaligned_c = is_misaligned(size_in, aluout_in[1:0]);
  // An op flagged both read and write is handled as a store.
  assign is_load_c    = cap_q.memread & ~cap_q.memwrite;

  mem_lane_align u_lane_align (
    .lane        (cap_q.aluout[1:0]),
    .size        (cap_q.size),
    .unsigned_ld (cap_q.unsigned_ld),
    .wdata       (cap_q.writedata),
    .rdata       (dmem.dmem_rdata),
    .be_c        (be_c),
    .wdata_c     (wdata_c),
    .rdata_c     (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cap_d           = cap_q;
    stall_mem       = 1'b0;
    misalign_mem    = 1'b0;
    regwrite_mem    = 1'b0;
    memtoreg_mem    = 1'b0;
    aluout_mem      = '0;
    readdata_mem    = '0;
    regaddr_mem     = '0;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_be    = '0;
    dmem.dmem_wdata = '0;

    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (mem_op_c && misaligned_c) begin
            misalign_mem = 1'b1;
            aluout_mem   = aluout_in;
            regaddr_mem  = regaddr_in;
          end else if (mem_op_c) begin
            cap_d = '{valid: valid_in, memread: memread_in, memwrite: memwrite_in,
                      size: size_in, unsigned_ld: unsigned_in, regwrite: regwrite_in,
                      memtoreg: memtoreg_in, aluout: aluout_in, writedata: writedata_in,
                      regaddr: regaddr_in};
            stall_mem = 1'b1;
            state_d   = ST_REQ;
          end else begin
            regwrite_mem = valid_in & regwrite_in;
            memtoreg_mem = memtoreg_in;
            aluout_mem   = aluout_in;
            regaddr_mem  = regaddr_in;
          end
        end

        ST_REQ: begin
          dmem.dmem_req   = 1'b1;
          dmem.dmem_we    = ~is_load_c;
          dmem.dmem_addr  = {cap_q.aluout[WIDTH-1:2], 2'b00};
          dmem.dmem_be    = be_c;
          dmem.dmem_wdata = wdata_c;
          if (dmem.dmem_gnt && !is_load_c) begin
            regwrite_mem = cap_q.valid & cap_q.regwrite;
            memtoreg_mem = cap_q.memtoreg;
            aluout_mem   = cap_q.aluout;
            regaddr_mem  = cap_q.regaddr;
            state_d      = ST_IDLE;
          end else if (dmem.dmem_gnt) begin
            stall_mem = 1'b1;
            state_d   = ST_RESP;
          end else begin
            stall_mem = 1'b1;
          end
        end

        ST_RESP: begin
          if (dmem.dmem_rvalid) begin
            regwrite_mem = cap_q.valid & cap_q.regwrite;
            memtoreg_mem = cap_q.memtoreg;
            aluout_mem   = cap_q.aluout;
            regaddr_mem  = cap_q.regaddr;
            readdata_mem = rdata_c;
            state_d      = ST_IDLE;
          end else begin
            stall_mem = 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
